// File: rtl/snake_step_scheduler_pkg.sv
// Shared types for the snake step scheduler: one-hot directions, game states,
// and the opposite-direction helper.
package snake_step_scheduler_pkg;

   localparam logic [3:0] DIR_UP    = 4'b0001;
   localparam logic [3:0] DIR_DOWN  = 4'b0010;
   localparam logic [3:0] DIR_LEFT  = 4'b0100;
   localparam logic [3:0] DIR_RIGHT = 4'b1000;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_RUN  = 3'd1,
      ST_STEP = 3'd2,
      ST_OVER = 3'd3
   } state_t;

   function automatic logic [3:0] dir_opposite(input logic [3:0] d);
      case (d)
         DIR_UP:    return DIR_DOWN;
         DIR_DOWN:  return DIR_UP;
         DIR_LEFT:  return DIR_RIGHT;
         DIR_RIGHT: return DIR_LEFT;
         default:   return 4'b0000;
      endcase
   endfunction

endpackage

// File: rtl/snake_step_scheduler_if.sv
// Scheduler <-> game datapath link: step request/ack handshake plus event reports.
interface snake_step_scheduler_if;
   logic       step_req;
   logic [3:0] step_dir;
   logic       step_ack;
   logic       apple_eaten;
   logic       collision;

   modport master (output step_req, step_dir, input step_ack, apple_eaten, collision);
   modport slave  (input step_req, step_dir, output step_ack, apple_eaten, collision);
endinterface

// File: rtl/snake_step_scheduler_dir_fifo.sv
// Shift-register direction queue: head at slot 0, tail at slot count-1, with flush.
module snake_step_scheduler_dir_fifo #(
   parameter int unsigned QDEPTH = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       flush,
   input  logic       push,
   input  logic       pop,
   input  logic [3:0] din,
   output logic [3:0] head,
   output logic [3:0] tail,
   output logic       full,
   output logic       empty
);

   logic [3:0] r_mem [QDEPTH];
   logic [2:0] r_count;
   logic       w_push;
   logic       w_pop;
   logic [2:0] w_wr_idx;

   assign full     = (r_count == 3'(QDEPTH));
   assign empty    = (r_count == 3'd0);
   assign w_push   = push & ~full;
   assign w_pop    = pop & ~empty;
   // A simultaneous pop shifts everything down, so the write lands one slot lower.
   assign w_wr_idx = w_pop ? (r_count - 3'd1) : r_count;
   assign head     = r_mem[0];

   always_comb begin
      tail = '0;
      for (int unsigned i = 0; i < QDEPTH; i++) begin
         if (3'(i) + 3'd1 == r_count) tail = r_mem[i];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_count <= '0;
         for (int unsigned i = 0; i < QDEPTH; i++) r_mem[i] <= '0;
      end else if (flush) begin
         r_count <= '0;
      end else begin
         if (w_pop) begin
            for (int unsigned i = 0; i + 1 < QDEPTH; i++) r_mem[i] <= r_mem[i+1];
         end
         if (w_push) begin
            for (int unsigned i = 0; i < QDEPTH; i++) begin
               if (3'(i) == w_wr_idx) r_mem[i] <= din;
            end
         end
         if (w_push && !w_pop)      r_count <= r_count + 3'd1;
         else if (w_pop && !w_push) r_count <= r_count - 3'd1;
      end
   end

endmodule

// File: rtl/snake_step_scheduler.sv
// Snake game sequencer: IDLE/RUN/STEP/OVER FSM, step prescaler, direction queue, BCD score.
// Optional SNAKE_SPEEDUP_EN shortens the step period as the tens digit grows.
module snake_step_scheduler
   import snake_step_scheduler_pkg::*;
#(
   parameter int unsigned TICK_DIV  = 25_000_000,
   parameter int unsigned CW        = 25,
   parameter int unsigned QDEPTH    = 2,
   parameter int unsigned TICK_STEP = 2_000_000,
   parameter int unsigned TICK_MIN  = 5_000_000
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       start,
   input  logic [3:0]                 movement,
   snake_step_scheduler_if.master     dp,
   output logic [2:0]                 state,
   output logic [3:0]                 ones,
   output logic [3:0]                 tens
);

`ifdef SNAKE_SPEEDUP_EN
   localparam bit LP_SPEEDUP = 1'b1;
`else
   localparam bit LP_SPEEDUP = 1'b0;
`endif

   state_t        r_state, w_state_nx;
   logic [CW-1:0] r_presc, r_period, w_next_period;
   logic [3:0]    r_cur_dir, r_mv_prev, r_ones, r_tens;
   logic          r_start_prev;
   logic          w_wrap, w_start_go, w_active, w_push, w_pop;
   logic [3:0]    w_ref, w_head, w_tail;
   logic          w_full, w_empty;
   logic signed [31:0] w_dec;

   assign w_active   = (r_state == ST_RUN) || (r_state == ST_STEP);
   assign w_start_go = ((r_state == ST_IDLE) || (r_state == ST_OVER)) && start && !r_start_prev;

   // New presses are judged against the last queued direction, or the live one if none queued.
   assign w_ref  = w_empty ? r_cur_dir : w_tail;
   assign w_push = w_active && (movement != r_mv_prev) && $onehot(movement)
                   && (movement != w_ref) && (movement != dir_opposite(w_ref)) && !w_full;
   assign w_pop  = w_wrap && !w_empty;

   always_comb begin
      w_dec = $signed(TICK_DIV) - $signed({28'd0, r_tens}) * $signed(TICK_STEP);
      if (!LP_SPEEDUP)                    w_next_period = CW'(TICK_DIV);
      else if (w_dec < $signed(TICK_MIN)) w_next_period = CW'(TICK_MIN);
      else                                w_next_period = CW'(w_dec);
   end

   snake_step_scheduler_dir_fifo #(.QDEPTH(QDEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .flush (w_start_go),
      .push  (w_push),
      .pop   (w_pop),
      .din   (movement),
      .head  (w_head),
      .tail  (w_tail),
      .full  (w_full),
      .empty (w_empty)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= ST_IDLE;
      else        r_state <= w_state_nx;
   end

   always_comb begin
      w_state_nx = r_state;
      w_wrap     = 1'b0;
      case (r_state)
         ST_IDLE, ST_OVER: if (w_start_go) w_state_nx = ST_RUN;
         ST_RUN: begin
            if (dp.collision) w_state_nx = ST_OVER;
            else if (r_presc == r_period - CW'(1)) begin
               w_wrap     = 1'b1;
               w_state_nx = ST_STEP;
            end
         end
         ST_STEP: begin
            if (dp.collision)     w_state_nx = ST_OVER;
            else if (dp.step_ack) w_state_nx = ST_RUN;
         end
         default: w_state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_presc      <= '0;
         r_period     <= CW'(TICK_DIV);
         r_cur_dir    <= DIR_RIGHT;
         r_ones       <= '0;
         r_tens       <= '0;
         r_start_prev <= 1'b0;
         r_mv_prev    <= '0;
      end else begin
         r_start_prev <= start;
         r_mv_prev    <= movement;
         if (w_start_go) begin
            r_presc   <= '0;
            r_period  <= CW'(TICK_DIV);
            r_cur_dir <= DIR_RIGHT;
            r_ones    <= '0;
            r_tens    <= '0;
         end else begin
            if (w_wrap) begin
               r_presc  <= '0;
               r_period <= w_next_period;
            end else if (r_state == ST_RUN && !dp.collision) begin
               r_presc <= r_presc + CW'(1);
            end
            if (w_pop) r_cur_dir <= w_head;
            if (w_active && dp.apple_eaten) begin
               if (r_ones != 4'd9) begin
                  r_ones <= r_ones + 4'd1;
               end else if (r_tens != 4'd9) begin
                  r_ones <= '0;
                  r_tens <= r_tens + 4'd1;
               end
            end
         end
      end
   end

   assign dp.step_req = (r_state == ST_STEP);
   assign dp.step_dir = r_cur_dir;
   assign state       = r_state;
   assign ones        = r_ones;
   assign tens        = r_tens;

endmodule

// File: tb/tb_snake_step_scheduler.sv
// Directed bench for snake_step_scheduler with TICK_DIV=10, QDEPTH=2.
module tb_snake_step_scheduler;

   localparam int unsigned TICK_DIV  = 10;
   localparam int unsigned CW        = 5;
   localparam int unsigned QDEPTH    = 2;
   localparam int unsigned TICK_STEP = 2;
   localparam int unsigned TICK_MIN  = 4;

   logic       clk = 1'b0;
   logic       reset, start;
   logic [3:0] movement;
   logic [2:0] state;
   logic [3:0] ones, tens;
   logic       force_ack = 1'b0, auto_ack = 1'b0, r_auto = 1'b0;

   int checks = 0, errors = 0;
   int cyc = 0, last_rise = 0, gap = 0, rise_cnt = 0, seen = 0, ack_cnt = 0;
   logic prev_req = 1'b0;

   snake_step_scheduler_if dp_if ();
   assign dp_if.step_ack = force_ack | r_auto;

   snake_step_scheduler #(
      .TICK_DIV(TICK_DIV), .CW(CW), .QDEPTH(QDEPTH),
      .TICK_STEP(TICK_STEP), .TICK_MIN(TICK_MIN)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .movement(movement),
      .dp(dp_if), .state(state), .ones(ones), .tens(tens)
   );

   always #5 clk = ~clk;

   // Step-request monitor and auto-ack responder (ack raised in the 2nd STEP cycle).
   always @(posedge clk) begin
      #2;
      cyc++;
      if (dp_if.step_req && !prev_req) begin
         rise_cnt++;
         gap       = cyc - last_rise;
         last_rise = cyc;
      end
      prev_req = dp_if.step_req;
      if (auto_ack && dp_if.step_req) begin
         ack_cnt++;
         r_auto = (ack_cnt == 2);
      end else begin
         ack_cnt = 0;
         r_auto  = 1'b0;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_rise(input string name);
      int n = 0;
      seen = rise_cnt;
      while (rise_cnt == seen && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (rise_cnt == seen) begin
         checks++;
         errors++;
         $display("FAIL %s: no step_req within 200 cycles", name);
      end
      seen = rise_cnt;
   endtask

   typedef struct {
      logic [3:0] m0, m1, m2, m3;
      logic [3:0] e1, e2;
   } dir_vec_t;

   typedef struct {
      int         pulses;
      logic [3:0] ones;
      logic [3:0] tens;
      int         gap_spd;
   } score_vec_t;

   dir_vec_t   dv [3];
   score_vec_t sv [5];

   initial begin
      logic [3:0] mv [4];
      int exp_gap;

      // cur_dir before each row: RIGHT, LEFT, RIGHT
      dv[0] = '{m0:4'b1000, m1:4'b0010, m2:4'b0100, m3:4'b0001, e1:4'b0010, e2:4'b0100};
      dv[1] = '{m0:4'b1000, m1:4'b0001, m2:4'b0010, m3:4'b1000, e1:4'b0001, e2:4'b1000};
      dv[2] = '{m0:4'b0110, m1:4'b0010, m2:4'b0010, m3:4'b0001, e1:4'b0010, e2:4'b0010};
      // cumulative apples 1, 9, 10, 19, 100 (saturates at 99)
      sv[0] = '{pulses:1,  ones:4'd1, tens:4'd0, gap_spd:0};
      sv[1] = '{pulses:8,  ones:4'd9, tens:4'd0, gap_spd:0};
      sv[2] = '{pulses:1,  ones:4'd0, tens:4'd1, gap_spd:0};
      sv[3] = '{pulses:9,  ones:4'd9, tens:4'd1, gap_spd:10};
      sv[4] = '{pulses:81, ones:4'd9, tens:4'd9, gap_spd:6};

      reset = 1'b0; start = 1'b0; movement = 4'b0000;
      dp_if.apple_eaten = 1'b0; dp_if.collision = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_req",   32'(dp_if.step_req), 32'd0);
      chk("rst_dir",   32'(dp_if.step_dir), 32'h8);
      chk("rst_ones",  32'(ones), 32'd0);
      chk("rst_tens",  32'(tens), 32'd0);

      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("start_state", 32'(state), 32'd1);
      auto_ack = 1'b1;

      wait_rise("step1");
      chk("step1_dir", 32'(dp_if.step_dir), 32'h8);
      wait_rise("step2");
      chk("step2_gap", 32'(gap), 32'd12);
      chk("step2_dir", 32'(dp_if.step_dir), 32'h8);
      wait_rise("step3");
      chk("step3_gap", 32'(gap), 32'd12);

      // reversal and non-one-hot presses are both dropped
      movement = 4'b0100;
      @(negedge clk);
      movement = 4'b0011;
      @(negedge clk);
      movement = 4'b0000;
      wait_rise("illegal");
      chk("illegal_dir", 32'(dp_if.step_dir), 32'h8);

      for (int i = 0; i < 3; i++) begin
         mv = '{dv[i].m0, dv[i].m1, dv[i].m2, dv[i].m3};
         for (int k = 0; k < 4; k++) begin
            movement = mv[k];
            @(negedge clk);
         end
         movement = 4'b0000;
         wait_rise("dirvec_a");
         chk($sformatf("dirvec%0d_first", i), 32'(dp_if.step_dir), 32'(dv[i].e1));
         wait_rise("dirvec_b");
         chk($sformatf("dirvec%0d_second", i), 32'(dp_if.step_dir), 32'(dv[i].e2));
      end

      // cur_dir=DOWN, queue empty: queue LEFT early, then press UP in the wrap cycle
      repeat (3) @(negedge clk);
      movement = 4'b0100;
      @(negedge clk);
      movement = 4'b0000;
      repeat (7) @(negedge clk);
      movement = 4'b0001;
      @(negedge clk);
      movement = 4'b0000;
      chk("pushpop_req", 32'(dp_if.step_req), 32'd1);
      chk("pushpop_dir1", 32'(dp_if.step_dir), 32'h4);
      wait_rise("pushpop");
      chk("pushpop_dir2", 32'(dp_if.step_dir), 32'h1);

      for (int i = 0; i < 5; i++) begin
         for (int p = 0; p < sv[i].pulses; p++) begin
            dp_if.apple_eaten = 1'b1;
            @(negedge clk);
         end
         dp_if.apple_eaten = 1'b0;
         chk($sformatf("score%0d_ones", i), 32'(ones), 32'(sv[i].ones));
         chk($sformatf("score%0d_tens", i), 32'(tens), 32'(sv[i].tens));
         if (sv[i].gap_spd != 0) begin
`ifdef SNAKE_SPEEDUP_EN
            exp_gap = sv[i].gap_spd;
`else
            exp_gap = 12;
`endif
            wait_rise("period_a");
            wait_rise("period_b");
            chk($sformatf("score%0d_gap", i), 32'(gap), 32'(exp_gap));
         end
      end

      // ack while in RUN is ignored
      repeat (3) @(negedge clk);
      force_ack = 1'b1;
      @(negedge clk);
      force_ack = 1'b0;
      chk("ack_in_run", 32'(state), 32'd1);

      // collision beats a same-cycle ack
      auto_ack = 1'b0;
      wait_rise("coll");
      force_ack = 1'b1;
      dp_if.collision = 1'b1;
      @(negedge clk);
      force_ack = 1'b0;
      dp_if.collision = 1'b0;
      chk("coll_state", 32'(state), 32'd3);
      chk("coll_req",   32'(dp_if.step_req), 32'd0);
      dp_if.apple_eaten = 1'b1;
      @(negedge clk);
      dp_if.apple_eaten = 1'b0;
      chk("over_apple", 32'(ones), 32'd9);

      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("restart_state", 32'(state), 32'd1);
      chk("restart_ones",  32'(ones), 32'd0);
      chk("restart_tens",  32'(tens), 32'd0);
      chk("restart_dir",   32'(dp_if.step_dir), 32'h8);

      // asynchronous reset while a step is pending
      auto_ack = 1'b1;
      wait_rise("midstep");
      reset = 1'b0;
      #1;
      chk("midstep_req",   32'(dp_if.step_req), 32'd0);
      chk("midstep_state", 32'(state), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

endmodule
